// File: rtl/io_timer_responder.sv
// Memory-mapped timer responder on the CPU external data bus.
// A 32-byte register window with programmable wait states in front of a prescaled compare timer.
module io_timer_responder #(
    parameter logic [63:0] BASE_ADDR   = 64'hFFFF_FFFF_FFFF_FF00,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned PRESCALE    = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] mem_addr,
    input  logic [63:0] mem_dout,
    input  logic        mem_addr_valid,
    input  logic        mem_dout_write,
    output logic [63:0] mem_din,
    output logic        mem_din_ready,
    output logic        irq
);

    localparam int WCNT_W = 4;
    localparam int PRE_W  = 16;
    localparam logic [WCNT_W-1:0] WS_LAST =
        WCNT_W'((WAIT_STATES == 0) ? 0 : WAIT_STATES - 1);
    localparam logic [PRE_W-1:0] PRE_LAST =
        PRE_W'((PRESCALE == 0) ? 0 : PRESCALE - 1);

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_COUNT  = 2'd1;
    localparam logic [1:0] IDX_CMP    = 2'd2;
    localparam logic [1:0] IDX_STATUS = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [63:0]        wdata_q, wdata_d;
    logic               we_q, we_d;

    logic [2:0]         ctrl_q, ctrl_d;
    logic [63:0]        count_q, count_d;
    logic [63:0]        cmp_q, cmp_d;
    logic               match_q, match_d;
    logic [PRE_W-1:0]   pre_q, pre_d;

    logic               sel;
    logic               resp;
    logic               commit;
    logic               wr_ctrl, wr_count, wr_cmp, wr_status;
    logic               tick;
    logic               hit;
    logic [63:0]        count_inc;
    logic [63:0]        rd_mux;
    logic               unused_addr_lsb;

    assign sel = mem_addr_valid && (mem_addr[63:5] == BASE_ADDR[63:5]);
    assign unused_addr_lsb = ^mem_addr[2:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            ctrl_q  <= '0;
            count_q <= '0;
            cmp_q   <= '0;
            match_q <= 1'b0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            ctrl_q  <= ctrl_d;
            count_q <= count_d;
            cmp_q   <= cmp_d;
            match_q <= match_d;
            pre_q   <= pre_d;
        end
    end

    // Bus inputs are only looked at in IDLE; WAIT/RESP run off the latched copy.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        case (state_q)
            S_IDLE: begin
                if (sel) begin
                    idx_d   = mem_addr[4:3];
                    wdata_d = mem_dout;
                    we_d    = mem_dout_write;
                    wcnt_d  = '0;
                    state_d = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (wcnt_q == WS_LAST) begin
                    state_d = S_RESP;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (idx_q)
            IDX_CTRL:   rd_mux = {61'd0, ctrl_q};
            IDX_COUNT:  rd_mux = count_q;
            IDX_CMP:    rd_mux = cmp_q;
            IDX_STATUS: rd_mux = {63'd0, match_q};
            default:    rd_mux = '0;
        endcase
    end

    always_comb begin
        resp          = (state_q == S_RESP);
        mem_din_ready = resp;
        mem_din       = (resp && !we_q) ? rd_mux : 64'd0;
        irq           = match_q & ctrl_q[2];
    end

    assign commit    = resp && we_q;
    assign wr_ctrl   = commit && (idx_q == IDX_CTRL);
    assign wr_count  = commit && (idx_q == IDX_COUNT);
    assign wr_cmp    = commit && (idx_q == IDX_CMP);
    assign wr_status = commit && (idx_q == IDX_STATUS);

    assign tick      = ctrl_q[0] && (pre_q == PRE_LAST);
    assign count_inc = count_q + 64'd1;
    // A bus load of COUNT overrides the tick, so that tick cannot raise a match.
    assign hit       = tick && !wr_count && (count_inc == cmp_q);

    always_comb begin
        pre_d = (!ctrl_q[0] || tick) ? '0 : pre_q + 1'b1;

        ctrl_d = wr_ctrl ? wdata_q[2:0] : ctrl_q;
        cmp_d  = wr_cmp  ? wdata_q      : cmp_q;

        if (wr_count)               count_d = wdata_q;
        else if (hit && ctrl_q[1])  count_d = 64'd0;
        else if (tick)              count_d = count_inc;
        else                        count_d = count_q;

        if (hit)                            match_d = 1'b1;
        else if (wr_status && wdata_q[0])   match_d = 1'b0;
        else                                match_d = match_q;
    end

endmodule

// File: doc/io_timer_responder.md
Name: io_timer_responder

Overview:
- Memory-mapped timer peripheral that sits on the external data bus in IO space.
- It is the responder end of the CPU's mem_addr / mem_dout / mem_dout_write / mem_din / mem_din_ready interface.
- It decodes a 32-byte register window, inserts programmable wait states, and returns read data with a one-cycle ready pulse.
- It provides a free-running/compare timer with a sticky match flag and an interrupt output.

Parameters:
- BASE_ADDR, 64'hFFFF_FFFF_FFFF_FF00: window base; bits [4:0] ignored.
- WAIT_STATES, 1: extra cycles between request accept and ready pulse (0..15).
- PRESCALE, 1: timer increments once every PRESCALE enabled cycles (1..65535).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- mem_addr  in  64  bus address from CPU
- mem_dout  in  64  write data from CPU
- mem_addr_valid  in  1  address valid
- mem_dout_write  in  1  write strobe; high = write request, low = read request
- mem_din  out  64  read data to CPU; valid only while mem_din_ready is high, else 64'h0
- mem_din_ready  out  1  one-cycle completion pulse for reads and writes
- irq  out  1  level interrupt = STATUS.match & CTRL.irq_en

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - All registers, state and prescaler go to 0; FSM goes to IDLE.
  - mem_din = 0, mem_din_ready = 0, irq = 0.
  - Asserting rst mid-transaction aborts it; no ready pulse and no register commit.
- Select: sel = mem_addr_valid & (mem_addr[63:5] == BASE_ADDR[63:5]).
  - Register index = mem_addr[4:3]; mem_addr[2:0] are ignored.
  - Out-of-window requests get no response and no state change.
- Register map, all 64-bit:
  - 0x00 CTRL: bit0 enable, bit1 auto_reload, bit2 irq_en; other bits read 0.
  - 0x08 COUNT: read = current count; write = load.
  - 0x10 COMPARE: read/write.
  - 0x18 STATUS: bit0 match, sticky; a write with bit0 = 1 clears it.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if sel, latch addr index, mem_dout and mem_dout_write; go to WAIT (go to RESP if WAIT_STATES = 0).
  - WAIT: wait-state counter counts WAIT_STATES cycles, then go to RESP. Bus inputs are ignored (latched values are used).
  - RESP: mem_din_ready = 1 for exactly one cycle.
    - Read: mem_din = register value sampled at the RESP cycle.
    - Write: the register commits at the end of the RESP cycle.
    - Next state is IDLE unconditionally, giving one dead cycle before the next accept.
- Latency: a request accepted at cycle 0 produces its ready pulse at cycle WAIT_STATES+1. A held request (mem_addr_valid tied 1) re-issues every WAIT_STATES+2 cycles.
- Timer:
  - While CTRL.enable = 1, the prescaler counts 0..PRESCALE-1; on wrap it produces a tick.
  - Each tick: COUNT <= COUNT+1 (64-bit, wraps from all-ones to 0).
  - The prescaler is held at 0 while enable = 0.
- Match: on a tick where the next count equals COMPARE:
  - STATUS.match <= 1.
  - If auto_reload, COUNT <= 0 instead of COMPARE.
- Simultaneous events:
  - A bus write to COUNT in the same cycle as a tick: the bus value wins, and the tick does not match.
  - A STATUS clear in the same cycle as a match: set wins.
  - A CTRL write that clears enable takes effect the next cycle.
- A read of COUNT returns the pre-update value of that cycle.

Test Plan:
- Reset/idle: assert rst 2 cycles, request in window -> mem_din_ready=0, mem_din=0, irq=0 during reset; first accept after rst low.
- Read latency: WAIT_STATES=1, read 0x10 after reset -> ready pulse exactly 2 cycles after accept, mem_din=0, ready high 1 cycle only.
- Write/readback: write COMPARE=64'h5, write CTRL=3'b111, read COMPARE -> mem_din=64'h5; out-of-window read at BASE+0x40 -> no ready ever.
- Timer match + reload: PRESCALE=1, COMPARE=5, enable+auto_reload+irq_en -> after 5 ticks STATUS.match=1, irq=1, COUNT=0; COUNT then restarts at 1.
- Clear vs set race: write STATUS=1 in the same cycle as a match -> match stays 1; a later clear with no match -> match=0, irq=0.
- Abort: assert rst during WAIT of a write to COMPARE=64'hAA -> no ready pulse; COMPARE reads 0 afterwards.
